// File: rtl/serial_adder_if.sv
// Operand/result bundle for serial_adder. When SERIAL_ADDER_SUB_EN is defined
// the bundle also carries the subtract select.
interface serial_adder_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
`ifdef SERIAL_ADDER_SUB_EN
    logic             sub;
`endif
    logic [WIDTH-1:0] sum;
    logic             carry;
    logic             busy;
    logic             done;

`ifdef SERIAL_ADDER_SUB_EN
    modport master (output start, a, b, sub, input  sum, carry, busy, done);
    modport slave  (input  start, a, b, sub, output sum, carry, busy, done);
`else
    modport master (output start, a, b, input  sum, carry, busy, done);
    modport slave  (input  start, a, b, output sum, carry, busy, done);
`endif
endinterface

// File: rtl/serial_adder.sv
// Bit-serial LSB-first adder: one full-adder cell reused over WIDTH clocks.
// Define SERIAL_ADDER_SUB_EN to add the sub input (a - b via ~b and carry-in 1).
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic           clk,
    input  logic           rst,
    serial_adder_if.slave  bus
);
    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] op_a_q, op_a_d;
    logic [WIDTH-1:0] op_b_q, op_b_d;
    logic             c_q, c_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;

    logic             s_bit;
    logic             c_next;
    logic             sub_sel;

`ifdef SERIAL_ADDER_SUB_EN
    assign sub_sel = bus.sub;
`else
    assign sub_sel = 1'b0;
`endif

    // The single shared cell: current LSBs plus the stored carry.
    assign s_bit  = op_a_q[0] ^ op_b_q[0] ^ c_q;
    assign c_next = (op_a_q[0] & op_b_q[0]) | (c_q & (op_a_q[0] ^ op_b_q[0]));

    always_comb begin
        // NOTE: every signal gets its hold value first so no path leaves it unassigned (no latch).
        state_d = state_q;
        op_a_d  = op_a_q;
        op_b_d  = op_b_q;
        c_d     = c_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        sum_d   = sum_q;
        carry_d = carry_q;

        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = ADD;
                    op_a_d  = bus.a;
                    op_b_d  = sub_sel ? ~bus.b : bus.b;
                    c_d     = sub_sel;
                    cnt_d   = '0;
                    res_d   = '0;
                end
            end
            ADD: begin
                c_d    = c_next;
                res_d  = {s_bit, res_q[WIDTH-1:1]};
                op_a_d = op_a_q >> 1;
                op_b_d = op_b_q >> 1;
                cnt_d  = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_BIT) begin
                    // Result registers only change here, so partial sums never show.
                    state_d = DONE;
                    sum_d   = {s_bit, res_q[WIDTH-1:1]};
                    carry_d = c_next;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            op_a_q  <= '0;
            op_b_q  <= '0;
            c_q     <= 1'b0;
            cnt_q   <= '0;
            res_q   <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
        end else begin
            state_q <= state_d;
            op_a_q  <= op_a_d;
            op_b_q  <= op_b_d;
            c_q     <= c_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
        end
    end

    assign bus.sum   = sum_q;
    assign bus.carry = carry_q;
    assign bus.busy  = (state_q != IDLE);
    assign bus.done  = (state_q == DONE);
endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder: driver pushes expected results, a
// negedge monitor pops and checks them on every done pulse.
module tb_serial_adder;
    localparam int WIDTH = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    serial_adder_if #(.WIDTH(WIDTH)) bus ();
    serial_adder #(.WIDTH(WIDTH)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        logic [WIDTH-1:0] sum;
        logic             carry;
        int               cyc;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   busy_run = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: plain arithmetic on whole operands.
    function automatic exp_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                   input logic sub, input int done_cyc);
        exp_t e;
        if (sub) begin
            e.sum   = a - b;
            e.carry = (a >= b);
        end else begin
            {e.carry, e.sum} = {1'b0, a} + {1'b0, b};
        end
        e.cyc = done_cyc;
        return e;
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            busy_run = 0;
        end else begin
            if (bus.done) begin
                check("done_expected", (sb_q.size() != 0), 1);
                if (sb_q.size() != 0) begin
                    mon_e = sb_q.pop_front();
                    check("sum", bus.sum, mon_e.sum);
                    check("carry", bus.carry, mon_e.carry);
                    check("done_cycle", cyc, mon_e.cyc);
                end
            end
            if (bus.busy) busy_run++;
            else if (busy_run != 0) begin
                check("busy_len", busy_run, WIDTH + 1);
                busy_run = 0;
            end
        end
    end

    task automatic drive_sub(input logic s);
`ifdef SERIAL_ADDER_SUB_EN
        bus.sub = s;
`else
        if (s) $display("note: sub ignored in add-only build");
`endif
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (!bus.busy) return;
        end
        check("idle_timeout", bus.busy, 0);
    endtask

    task automatic start_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                            input logic s, output int acc);
        wait_idle();
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = a;
        bus.b     = b;
        drive_sub(s);
        @(posedge clk);
        #1;
        acc = cyc;
        sb_q.push_back(model(a, b, s, acc + WIDTH));
        @(negedge clk);
        bus.start = 1'b0;
        bus.a     = WIDTH'($urandom);
        bus.b     = WIDTH'($urandom);
        drive_sub(1'b0);
    endtask

    initial begin
        int acc;
        logic [WIDTH-1:0] ra, rb;
        logic rs;

        rst = 1'b0;
        bus.start = 1'b0;
        bus.a = '0;
        bus.b = '0;
        drive_sub(1'b0);
        #1 rst = 1'b1;
        #3;
        check("rst_sum", bus.sum, 0);
        check("rst_carry", bus.carry, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        @(negedge clk);
        rst = 1'b0;

        // Carry-out, then no carry.
        start_op(8'hFF, 8'h01, 1'b0, acc);
        start_op(8'h35, 8'h4A, 1'b0, acc);

        // Start pulses during ADD must be ignored.
        start_op(8'hFF, 8'h01, 1'b0, acc);
        repeat (2) @(negedge clk);
        bus.start = 1'b1;
        bus.a = 8'h11;
        bus.b = 8'h22;
        repeat (3) @(negedge clk);
        bus.start = 1'b0;
        wait_idle();
        repeat (3) @(negedge clk);
        check("ignored_start_sum", bus.sum, 8'h00);
        check("ignored_start_carry", bus.carry, 1);

        // Start held high: one operation every WIDTH+2 cycles.
        wait_idle();
        @(negedge clk);
        bus.start = 1'b1;
        bus.a = 8'h80;
        bus.b = 8'h80;
        @(posedge clk);
        #1;
        acc = cyc;
        for (int k = 0; k < 3; k++)
            sb_q.push_back(model(8'h80, 8'h80, 1'b0, acc + WIDTH + k * (WIDTH + 2)));
        repeat (2 * (WIDTH + 2)) @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;

`ifdef SERIAL_ADDER_SUB_EN
        start_op(8'h10, 8'h01, 1'b1, acc);
        start_op(8'h01, 8'h02, 1'b1, acc);
`endif

        // Abort mid-ADD: outputs clear at once and no done follows.
        start_op(8'hA5, 8'h3C, 1'b0, acc);
        repeat (3) @(posedge clk);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("abort_sum", bus.sum, 0);
        check("abort_carry", bus.carry, 0);
        check("abort_busy", bus.busy, 0);
        check("abort_done", bus.done, 0);
        sb_q.delete();
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        check("post_abort_busy", bus.busy, 0);

        // Randomized operands.
        for (int i = 0; i < 24; i++) begin
            ra = WIDTH'($urandom);
            rb = WIDTH'($urandom);
`ifdef SERIAL_ADDER_SUB_EN
            rs = 1'($urandom_range(0, 1));
`else
            rs = 1'b0;
`endif
            if (i == 0) rb = ~ra;
            start_op(ra, rb, rs, acc);
        end

        wait_idle();
        for (int i = 0; i < 50 && sb_q.size() != 0; i++) @(negedge clk);
        check("scoreboard_drained", sb_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
